// File: rtl/beam_pkg.sv
// Shared types and constants for the beam-sum front end: sample/sum widths,
// the accumulator state encoding and the sign-extension helper.
package beam_pkg;

    localparam int SAMPLE_W = 16;
    localparam int SUM_W    = 19;
    localparam int MAX_CH   = 8;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic signed [SUM_W-1:0]    sum_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } acc_state_t;

    function automatic sum_t sext(input sample_t s);
        return {{(SUM_W - SAMPLE_W){s[SAMPLE_W-1]}}, s};
    endfunction

endpackage

// File: rtl/adder_19bit.sv
// Team 19-bit ripple-carry adder: a chain of full adders, LSB first.
module adder_19bit (
    input  logic [18:0] a_i,
    input  logic [18:0] b_i,
    input  logic        cin_i,
    output logic [18:0] sum_o,
    output logic        cout_o
);

    logic [19:0] carry;

    assign carry[0] = cin_i;

    for (genvar i = 0; i < 19; i++) begin : g_fa
        assign sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
        assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end

    assign cout_o = carry[19];

endmodule

// File: rtl/beam_sum_accumulator.sv
// Delay-and-sum front end: adds NUM_CH consecutive signed samples (one per
// channel, channel 0 flagged by s_first) and holds the 19-bit sum for downstream.
module beam_sum_accumulator
    import beam_pkg::*;
#(
    parameter int NUM_CH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [SAMPLE_W-1:0] s_data,
    input  logic                s_first,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [SUM_W-1:0]    m_data,
    output logic                frame_err,
    output logic [2:0]          ch_idx,
    output acc_state_t          dbg_state
);

    // Handshake: a sample moves on a rising edge with s_valid && s_ready; the
    // sum moves with m_valid && m_ready. s_ready depends only on registered state.

    if (NUM_CH < 2 || NUM_CH > MAX_CH) begin : g_bad_num_ch
        $error("beam_sum_accumulator: NUM_CH must be within 2..%0d", MAX_CH);
    end

    localparam logic [2:0] LAST_CH = 3'(NUM_CH - 1);

    acc_state_t state_q, state_d;
    sum_t       acc_q, acc_d;
    sum_t       m_data_q, m_data_d;
    logic [2:0] ch_q, ch_d;
    logic       m_valid_q, m_valid_d;
    logic       err_q, err_d;

    sum_t       sample_ext;
    logic [SUM_W-1:0] add_sum;
    logic       adder_cout_unused;
    logic       accept;

    assign sample_ext = sext(s_data);
    assign s_ready    = (state_q != HOLD);
    assign accept     = s_valid && s_ready && !clr;

    adder_19bit u_adder (
        .a_i    (acc_q),
        .b_i    (sample_ext),
        .cin_i  (1'b0),
        .sum_o  (add_sum),
        .cout_o (adder_cout_unused)
    );

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        ch_d      = ch_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        err_d     = 1'b0;
        if (clr) begin
            state_d   = IDLE;
            acc_d     = '0;
            ch_d      = '0;
            m_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (s_first) begin
                            acc_d   = sample_ext;
                            ch_d    = 3'd1;
                            state_d = ACCUM;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        // A stray s_first restarts the frame on this sample.
                        if (s_first) begin
                            err_d = 1'b1;
                            acc_d = sample_ext;
                            ch_d  = 3'd1;
                        end else if (ch_q == LAST_CH) begin
                            m_data_d  = add_sum;
                            m_valid_d = 1'b1;
                            acc_d     = '0;
                            ch_d      = '0;
                            state_d   = HOLD;
                        end else begin
                            acc_d = add_sum;
                            ch_d  = ch_q + 3'd1;
                        end
                    end
                end
                HOLD: begin
                    if (m_ready) begin
                        m_valid_d = 1'b0;
                        state_d   = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            ch_q      <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            ch_q      <= ch_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            err_q     <= err_d;
        end
    end

    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign frame_err = err_q;
    assign ch_idx    = ch_q;
    assign dbg_state = state_q;

endmodule

// File: doc/beam_sum_accumulator.md
Name: beam_sum_accumulator

Overview:
- Delay-and-sum front end: accepts one delayed 16-bit signed microphone sample per cycle.
- Sums NUM_CH consecutive samples, one per channel, into a 19-bit signed frame sum.
- The addition itself goes through the team's 19-bit ripple adder; this block supplies sequencing, sign extension, buffering and handshakes.
- Sits between the per-channel delay lines (upstream) and the beam power/decimation stage (downstream).

Parameters:
- NUM_CH, 8, channels summed per frame; legal range 2..8, so the sum always fits 19-bit signed.
- SAMPLE_W, 16, input sample width; fixed at 16 in this revision (16 + 3 = 19).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous abort: discards the partial frame and any held result.
- s_valid  input  1  upstream sample valid.
- s_ready  output  1  block can accept a sample this cycle.
- s_data  input  16  signed two's-complement sample.
- s_first  input  1  qualifies s_data as channel 0 of a frame.
- m_valid  output  1  frame sum valid.
- m_ready  input  1  downstream accepts the sum.
- m_data  output  19  signed frame sum.
- frame_err  output  1  one-cycle pulse: s_first/channel-count mismatch detected.
- ch_idx  output  3  index of the next channel expected.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, acc=0, ch_idx=0, m_valid=0, m_data=0, frame_err=0; s_ready=1 after release.
- Transfers: input on s_valid && s_ready at the clock edge; output on m_valid && m_ready.
- States and transitions:
  - IDLE: s_ready=1. Accepted sample with s_first=1: acc<=sext(s_data), ch_idx<=1, go ACCUM. Accepted sample with s_first=0: dropped, frame_err pulses, stay IDLE.
  - ACCUM: s_ready=1. Accepted sample with s_first=0: acc<=acc+sext(s_data) via adder_19bit, ch_idx increments.
    - On the NUM_CH-th sample: m_data<=final sum, m_valid<=1, ch_idx<=0, go HOLD.
    - Accepted sample with s_first=1 mid-frame: frame_err pulses, acc restarts with this sample, ch_idx<=1, stay ACCUM (resync).
  - HOLD: s_ready=0; m_valid and m_data stable until m_ready. On m_valid && m_ready: m_valid<=0, go IDLE.
- Latency and throughput:
  - Sum valid on the cycle after the last sample is accepted.
  - Minimum frame period NUM_CH+1 cycles, because HOLD blocks input for at least one cycle.
  - No combinational path from m_ready to s_ready.
- Arithmetic:
  - sext replicates bit 15 into bits 18:16.
  - adder_19bit carry_out is ignored; 19-bit two's-complement wrap cannot occur for NUM_CH<=8.
  - The first sample of a frame bypasses the adder (b operand forced to 0 is also acceptable).
- clr: highest priority.
  - Next state IDLE, acc=0, ch_idx=0, m_valid=0; no frame_err.
  - A sample presented in the same cycle is dropped, even though s_ready=1.
- frame_err is a registered single-cycle pulse per offending sample; it does not stall the stream.
- Reset asserted mid-frame or in HOLD: immediate return to reset values; the held result is lost.
- NUM_CH outside 2..8: elaboration error via a generate-time check.

Decomposition:
- Shared package beam_pkg:
  - SAMPLE_W=16, SUM_W=19.
  - Typedefs sample_t (signed 16) and sum_t (signed 19).
  - State enum acc_state_t {IDLE, ACCUM, HOLD}.
  - MAX_CH=8.
- One sub-module: the existing adder_19bit, instantiated once as the accumulate datapath.
  - Operand a = acc.
  - Operand b = sext(s_data).
- Everything else (FSM, channel counter, output register) stays in this module.

Test Plan:
- Basic sum: NUM_CH=8, channels 0..7 = 1,2,3,4,5,6,7,8, s_first on ch0, m_ready=1 → m_data=36 one cycle after the 8th sample; m_valid high exactly 1 cycle; s_ready low that cycle.
- Extremes and sign: 8 × 16'h8000 → m_data = -262144 = 19'h40000. 8 × 16'h7FFF → 19'h3FFF8. Mixed (-5,+3,...) checked against a signed reference model.
- Backpressure: m_ready=0 for 10 cycles after a sum is produced → m_data stable, s_ready=0, upstream samples not consumed. Raise m_ready → handshake completes, next frame accepted from IDLE.
- Resync: s_first asserted on the 4th sample of a frame → frame_err pulses 1 cycle, ch_idx=1; the following 7 samples complete a correct new frame. A sample without s_first in IDLE is dropped and pulses frame_err.
- clr and reset mid-frame: clr after 5 samples → no m_valid, ch_idx=0, next frame correct. rst_n pulsed low asynchronously (between edges) during HOLD → m_valid and m_data drop to 0 immediately.
- Parameter sweep NUM_CH=2 and NUM_CH=5, random stalls on both s_valid and m_ready, 10k frames → scoreboard matches, no lost or duplicated frames.
